// File: rtl/nib_serial_add.sv
// Nibble-serial adder: {co, s} = a + b + ci, one 4-bit nibble per cycle, LSB nibble first.
// Optional macro NIB_SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand set
// RUN   | adding nibble cnt of the captured operands each cycle
// DONE  | result complete; out_valid raised one cycle after entry, held until accepted
module nib_serial_add #(
  parameter int NIB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NIB-1:0]  a,
  input  logic [4*NIB-1:0]  b,
  input  logic              ci,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NIB-1:0]  s,
  output logic              co
`ifdef NIB_SERIAL_ADD_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int W  = 4 * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [4:0]    nib_sum;

  always_comb begin
    nib_sum = {1'b0, a_r[{cnt, 2'b00} +: 4]} + {1'b0, b_r[{cnt, 2'b00} +: 4]} + {4'b0000, carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
`ifdef NIB_SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry    <= ci;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s[{cnt, 2'b00} +: 4] <= nib_sum[3:0];
          carry                <= nib_sum[4];
          cnt                  <= cnt + 1'b1;
          if (cnt == LAST) begin
            co    <= nib_sum[4];
`ifdef NIB_SERIAL_ADD_OVF_EN
            // nib_sum[3] is the final s[W-1] written on this same edge
            ovf   <= (a_r[W-1] == b_r[W-1]) && (nib_sum[3] != a_r[W-1]);
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/nib_serial_add.md
NIB_SERIAL_ADD -- requirements
Module: nib_serial_add

Interface
REQ-001 SHALL have parameter: NIB, default 4, number of 4-bit nibbles per operand (legal 1..8); W = 4*NIB.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand set a/b/ci valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have port: a  input  W  addend a.
REQ-007 SHALL have port: b  input  W  addend b.
REQ-008 SHALL have port: ci  input  1  carry in.
REQ-009 SHALL have port: out_valid  output  1  result s/co valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: s  output  W  sum.
REQ-012 SHALL have port: co  output  1  carry out of bit W-1.

Function
REQ-013 SHALL compute {co, s} = a + b + ci, unsigned, W+1 bits exact, one 4-bit nibble add per cycle, LSB nibble first.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge SHALL capture a, b, ci, clear nibble counter, go RUN.
REQ-016 RUN: each edge SHALL add the current nibble pair plus the carry register, store the 4-bit sum into nibble position = counter, update the carry register, increment the counter.
REQ-017 RUN SHALL last exactly NIB cycles; on the edge that processes nibble NIB-1, go DONE.
REQ-018 out_valid SHALL rise exactly NIB+1 edges after the accepting edge; the accepting edge is counted as edge 0.
REQ-019 DONE: out_valid=1; s and co SHALL stay stable until handshake; out_valid&&out_ready at an edge SHALL go IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored, with no capture and no error.
REQ-021 A new operand SHALL NOT be accepted on the DONE-exit edge; earliest acceptance is the following edge.
REQ-022 s/co SHALL hold the last result after leaving DONE until overwritten by the next RUN.
REQ-023 Carry out of the top nibble SHALL drive co; no carry SHALL wrap into nibble 0.
REQ-024 Operand changes on a/b/ci after acceptance SHALL NOT affect the result.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, s=0, co=0, counter=0, carry register=0.
REQ-026 rst SHALL override every other input, including in_valid and out_ready in the same cycle.
REQ-027 rst during RUN or DONE SHALL discard the in-flight operation; no out_valid SHALL be produced for it.
REQ-028 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-029 Macro NIB_SERIAL_ADD_OVF_EN, when defined, SHALL add port ovf  output  1  two's-complement signed overflow of a+b+ci.
REQ-030 ovf SHALL equal (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]), using the captured operands.
REQ-031 ovf SHALL be valid with out_valid, held like s, and reset to 0.
REQ-032 Without the macro, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (NIB=4)
REQ-033 a=0x1234, b=0x4321, ci=0, out_ready=1: s=0x5555, co=0, out_valid exactly 5 edges after acceptance.
REQ-034 a=0xFFFF, b=0x0001, ci=0 SHALL give s=0x0000, co=1; a=0xFFFF, b=0x0000, ci=1 SHALL give s=0x0000, co=1 (full carry ripple across nibbles).
REQ-035 Backpressure with out_ready=0 for 10 cycles in DONE: out_valid=1 and s/co stable throughout; in_valid pulses in RUN/DONE ignored; one result per accepted set.
REQ-036 rst asserted on the 2nd RUN cycle of 0x0F0F+0x0101: next cycle IDLE, s=0, co=0, out_valid never asserts; a fresh 0x0001+0x0001 then yields s=0x0002.
REQ-037 With NIB_SERIAL_ADD_OVF_EN: 0x7FFF+0x0001 SHALL give s=0x8000, ovf=1, co=0; 0x8000+0x8000 SHALL give s=0x0000, ovf=1, co=1; 0x0001+0x0001 SHALL give ovf=0.
REQ-038 Back-to-back operand sets with in_valid held high and out_ready=1: acceptances SHALL be exactly NIB+3 edges apart.
